// File: rtl/mc_router_pkg.sv
// Shared router definitions: port indices, flit mask field, port masks.
// Used by the multicast switch allocator and its arbiters.
package mc_router_pkg;

  localparam int NPORT = 5;
  localparam int FLIT_W = 30;
  localparam int MASK_HI = FLIT_W - 1;
  localparam int MASK_LO = FLIT_W - NPORT;

  localparam int P_N = 0;
  localparam int P_E = 1;
  localparam int P_S = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  typedef logic [NPORT-1:0] port_mask_t;

endpackage

// File: rtl/mc_switch_alloc_if.sv
// Per-port link: FIFO head and pop toward the input side,
// registered flit and almost-full toward the downstream side.
interface mc_switch_alloc_if
  import mc_router_pkg::*;
#(
  parameter int DATASIZE = FLIT_W
);

  logic [DATASIZE-1:0] data_in;
  logic                valid_in;
  logic                fifo_ready;
  logic [DATASIZE-1:0] data_out;
  logic                valid_out;
  logic                full_in;

  modport master (
    input  data_in, valid_in, full_in,
    output fifo_ready, data_out, valid_out
  );

  modport slave (
    output data_in, valid_in, full_in,
    input  fifo_ready, data_out, valid_out
  );

endinterface

// File: rtl/mc_switch_alloc_rr_arb5.sv
// Five-way round-robin arbiter; the search starts after the last winner.
// The pointer only moves on a grant.
module rr_arb5
  import mc_router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  port_mask_t req,
  input  logic       en,
  output port_mask_t gnt
);

  logic [2:0] ptr;

  always_comb begin
    int c;
    logic found;
    gnt = '0;
    found = 1'b0;
    c = 0;
    if (en) begin
      for (int k = 1; k <= NPORT; k++) begin
        c = (int'(ptr) + k) % NPORT;
        if (!found && req[c]) begin
          gnt[c] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 3'(P_L);
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (gnt[i]) ptr <= 3'(i);
      end
    end
  end

endmodule

// File: rtl/mc_switch_alloc.sv
// Multicast switch allocator with registered crossbar.
// A head pops only once every output in its mask has been served.
module mc_switch_alloc
  import mc_router_pkg::*;
#(
  parameter int DATASIZE = FLIT_W
)(
  input logic sw_clk,
  input logic rst,
  mc_switch_alloc_if.master port_n,
  mc_switch_alloc_if.master port_e,
  mc_switch_alloc_if.master port_s,
  mc_switch_alloc_if.master port_w,
  mc_switch_alloc_if.master port_l
);

  logic [DATASIZE-1:0] din [NPORT];
  logic [DATASIZE-1:0] xbar [NPORT];
  logic [DATASIZE-1:0] dout_q [NPORT];
  logic [NPORT-1:0] vin, full, pop;
  logic [NPORT-1:0] vout_q, pend;
  port_mask_t req [NPORT];
  port_mask_t resid [NPORT];
  port_mask_t req_col [NPORT];
  port_mask_t gnt_col [NPORT];
  port_mask_t gnt_row [NPORT];

  assign din[P_N] = port_n.data_in;
  assign din[P_E] = port_e.data_in;
  assign din[P_S] = port_s.data_in;
  assign din[P_W] = port_w.data_in;
  assign din[P_L] = port_l.data_in;
  assign vin = {port_l.valid_in, port_w.valid_in,
    port_s.valid_in, port_e.valid_in, port_n.valid_in};
  assign full = {port_l.full_in, port_w.full_in,
    port_s.full_in, port_e.full_in, port_n.full_in};

  assign port_n.fifo_ready = pop[P_N];
  assign port_e.fifo_ready = pop[P_E];
  assign port_s.fifo_ready = pop[P_S];
  assign port_w.fifo_ready = pop[P_W];
  assign port_l.fifo_ready = pop[P_L];
  assign port_n.data_out = dout_q[P_N];
  assign port_e.data_out = dout_q[P_E];
  assign port_s.data_out = dout_q[P_S];
  assign port_w.data_out = dout_q[P_W];
  assign port_l.data_out = dout_q[P_L];
  assign port_n.valid_out = vout_q[P_N];
  assign port_e.valid_out = vout_q[P_E];
  assign port_s.valid_out = vout_q[P_S];
  assign port_w.valid_out = vout_q[P_W];
  assign port_l.valid_out = vout_q[P_L];

  // A pending flit asks only for what it is still owed.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      req[i] = '0;
      if (pend[i]) req[i] = resid[i];
      else if (vin[i]) req[i] = din[i][DATASIZE-1 -: NPORT];
    end
    for (int o = 0; o < NPORT; o++) begin
      req_col[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        req_col[o][i] = req[i][o];
      end
    end
  end

  for (genvar o = 0; o < NPORT; o++) begin : g_arb
    rr_arb5 u_arb (
      .clk (sw_clk),
      .rst (rst),
      .req (req_col[o]),
      .en  (!full[o]),
      .gnt (gnt_col[o])
    );
  end

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      gnt_row[i] = '0;
      for (int o = 0; o < NPORT; o++) begin
        gnt_row[i][o] = gnt_col[o][i];
      end
      pop[i] = !rst && vin[i] &&
        ((req[i] & ~gnt_row[i]) == '0);
    end
    for (int o = 0; o < NPORT; o++) begin
      xbar[o] = '0;
      for (int i = 0; i < NPORT; i++) begin
        if (gnt_col[o][i]) xbar[o] = xbar[o] | din[i];
      end
    end
  end

  always_ff @(posedge sw_clk) begin
    if (rst) begin
      pend <= '0;
      vout_q <= '0;
      for (int i = 0; i < NPORT; i++) begin
        resid[i] <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        vout_q[o] <= |gnt_col[o];
        if (|gnt_col[o]) dout_q[o] <= xbar[o];
      end
      for (int i = 0; i < NPORT; i++) begin
        if (pop[i]) begin
          pend[i] <= 1'b0;
          resid[i] <= '0;
        end else if (|gnt_row[i]) begin
          pend[i] <= 1'b1;
          resid[i] <= req[i] & ~gnt_row[i];
        end
      end
    end
  end

endmodule
